// File: rtl/l1d_evict_wr_adapter.sv
// L1D eviction write adapter: buffers dirty lines and writes each one as a single AXI INCR burst.
// Define L1D_EVICT_BERR_EN to add the write-error pulse and sticky outputs.
module l1d_evict_wr_adapter #(
   parameter int LINE_W   = 512,
   parameter int DATA_W   = 128,
   parameter int ADDR_W   = 40,
   parameter int ID_W     = 4,
   parameter int AXI_ID_W = 4,
   parameter int AXI_ID   = 0,
   parameter int DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  evict_in_vld,
   output logic                  evict_in_rdy,
   input  logic [ID_W-1:0]       evict_in_id,
   input  logic [ADDR_W-1:0]     evict_in_addr,
   input  logic [LINE_W-1:0]     evict_in_data,
   output logic                  evict_dat_ram_clean_en,
   output logic [ID_W-1:0]       evict_dat_ram_clean_id,
`ifdef L1D_EVICT_BERR_EN
   output logic                  evict_berr_en,
   output logic                  evict_berr_sticky,
`endif
   output logic                  axi_awvalid,
   input  logic                  axi_awready,
   output logic [AXI_ID_W-1:0]   axi_awid,
   output logic [ADDR_W-1:0]     axi_awaddr,
   output logic [1:0]            axi_awburst,
   output logic [2:0]            axi_awsize,
   output logic [7:0]            axi_awlen,
   output logic                  axi_wvalid,
   input  logic                  axi_wready,
   output logic [DATA_W-1:0]     axi_wdata,
   output logic [DATA_W/8-1:0]   axi_wstrb,
   output logic                  axi_wlast,
   input  logic                  axi_bvalid,
   output logic                  axi_bready,
   input  logic [AXI_ID_W-1:0]   axi_bid,
   input  logic [1:0]            axi_bresp
);

   localparam int BEATS = LINE_W / DATA_W;
   localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW    = $clog2(DEPTH) + 1;

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   aw_ptr_q, aw_ptr_d;
   logic [PW-1:0]   w_ptr_q, w_ptr_d;
   logic [PW-1:0]   b_ptr_q, b_ptr_d;
   logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
   logic            clean_en_q, clean_en_d;
   logic [ID_W-1:0] clean_id_q, clean_id_d;

   logic [ID_W-1:0]                 id_q   [DEPTH];
   logic [ADDR_W-1:0]               addr_q [DEPTH];
   logic [BEATS-1:0][DATA_W-1:0]    data_q [DEPTH];

   logic push_s, aw_hs_s, w_hs_s, b_hs_s, last_s;
   logic [PW-2:0] wr_idx_s, aw_idx_s, w_idx_s, b_idx_s;

   assign wr_idx_s = wr_ptr_q[PW-2:0];
   assign aw_idx_s = aw_ptr_q[PW-2:0];
   assign w_idx_s  = w_ptr_q[PW-2:0];
   assign b_idx_s  = b_ptr_q[PW-2:0];

   // Handshakes and channel valids derive only from registered pointer state
   assign evict_in_rdy = (wr_ptr_q - b_ptr_q) != PW'(DEPTH);
   assign axi_awvalid  = aw_ptr_q != wr_ptr_q;
   assign axi_wvalid   = w_ptr_q != aw_ptr_q;
   assign axi_bready   = b_ptr_q != w_ptr_q;

   assign push_s  = evict_in_vld & evict_in_rdy;
   assign aw_hs_s = axi_awvalid & axi_awready;
   assign w_hs_s  = axi_wvalid & axi_wready;
   assign b_hs_s  = axi_bvalid & axi_bready;
   assign last_s  = beat_cnt_q == BC_W'(BEATS - 1);

   assign axi_awid    = AXI_ID_W'(AXI_ID);
   assign axi_awaddr  = addr_q[aw_idx_s];
   assign axi_awburst = 2'b01;
   assign axi_awsize  = 3'($clog2(DATA_W / 8));
   assign axi_awlen   = 8'(BEATS - 1);
   assign axi_wdata   = data_q[w_idx_s][beat_cnt_q];
   assign axi_wstrb   = '1;
   assign axi_wlast   = last_s;

   assign evict_dat_ram_clean_en = clean_en_q;
   assign evict_dat_ram_clean_id = clean_id_q;

   // Next-state for pointers, beat counter and the clean pulse
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      aw_ptr_d   = aw_ptr_q;
      w_ptr_d    = w_ptr_q;
      b_ptr_d    = b_ptr_q;
      beat_cnt_d = beat_cnt_q;
      clean_en_d = b_hs_s;
      clean_id_d = clean_id_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (aw_hs_s) begin
         aw_ptr_d = aw_ptr_q + PW'(1);
      end else begin
         aw_ptr_d = aw_ptr_q;
      end
      if (w_hs_s && last_s) begin
         beat_cnt_d = '0;
         w_ptr_d    = w_ptr_q + PW'(1);
      end else if (w_hs_s) begin
         beat_cnt_d = beat_cnt_q + BC_W'(1);
      end else begin
         beat_cnt_d = beat_cnt_q;
      end
      if (b_hs_s) begin
         b_ptr_d    = b_ptr_q + PW'(1);
         clean_id_d = id_q[b_idx_s];
      end else begin
         b_ptr_d    = b_ptr_q;
      end
   end

   // Control state with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         aw_ptr_q   <= '0;
         w_ptr_q    <= '0;
         b_ptr_q    <= '0;
         beat_cnt_q <= '0;
         clean_en_q <= 1'b0;
         clean_id_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         aw_ptr_q   <= aw_ptr_d;
         w_ptr_q    <= w_ptr_d;
         b_ptr_q    <= b_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         clean_en_q <= clean_en_d;
         clean_id_q <= clean_id_d;
      end
   end

   // Entry storage needs no reset: entries are only read between push and retire
   always_ff @(posedge clk) begin
      if (push_s) begin
         id_q[wr_idx_s]   <= evict_in_id;
         addr_q[wr_idx_s] <= evict_in_addr;
         data_q[wr_idx_s] <= evict_in_data;
      end
   end

`ifdef L1D_EVICT_BERR_EN
   logic berr_en_q, berr_sticky_q;
   logic berr_s;
   logic unused_ok;

   assign berr_s            = b_hs_s & (axi_bresp != 2'b00);
   assign evict_berr_en     = berr_en_q;
   assign evict_berr_sticky = berr_sticky_q;
   assign unused_ok         = ^axi_bid;

   // Error pulse aligns with the clean pulse; the sticky flag only clears on reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         berr_en_q     <= 1'b0;
         berr_sticky_q <= 1'b0;
      end else begin
         berr_en_q     <= berr_s;
         berr_sticky_q <= berr_sticky_q | berr_s;
      end
   end
`else
   logic unused_ok;
   assign unused_ok = ^{axi_bid, axi_bresp};
`endif

endmodule

// File: tb/tb_l1d_evict_wr_adapter.sv
// Directed bench for l1d_evict_wr_adapter at default parameters (512-bit line, 128-bit beats, 4 entries).
module tb_l1d_evict_wr_adapter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         evict_in_vld;
   logic         evict_in_rdy;
   logic [3:0]   evict_in_id;
   logic [39:0]  evict_in_addr;
   logic [511:0] evict_in_data;
   logic         clean_en;
   logic [3:0]   clean_id;
   logic         awvalid, awready;
   logic [3:0]   awid;
   logic [39:0]  awaddr;
   logic [1:0]   awburst;
   logic [2:0]   awsize;
   logic [7:0]   awlen;
   logic         wvalid, wready;
   logic [127:0] wdata;
   logic [15:0]  wstrb;
   logic         wlast;
   logic         bvalid, bready;
   logic [3:0]   bid;
   logic [1:0]   bresp;
`ifdef L1D_EVICT_BERR_EN
   logic         berr_en, berr_sticky;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   l1d_evict_wr_adapter dut (
      .clk(clk), .rst_n(rst_n),
      .evict_in_vld(evict_in_vld), .evict_in_rdy(evict_in_rdy),
      .evict_in_id(evict_in_id), .evict_in_addr(evict_in_addr), .evict_in_data(evict_in_data),
      .evict_dat_ram_clean_en(clean_en), .evict_dat_ram_clean_id(clean_id),
`ifdef L1D_EVICT_BERR_EN
      .evict_berr_en(berr_en), .evict_berr_sticky(berr_sticky),
`endif
      .axi_awvalid(awvalid), .axi_awready(awready), .axi_awid(awid), .axi_awaddr(awaddr),
      .axi_awburst(awburst), .axi_awsize(awsize), .axi_awlen(awlen),
      .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
      .axi_bvalid(bvalid), .axi_bready(bready), .axi_bid(bid), .axi_bresp(bresp)
   );

   function automatic logic [127:0] beat_of(input int k, input int b);
      logic [31:0] w;
      w = 32'hA500_0000 | 32'(k << 8) | 32'(b);
      return {w, w, w, w};
   endfunction

   function automatic logic [511:0] line_of(input int k);
      return {beat_of(k, 3), beat_of(k, 2), beat_of(k, 1), beat_of(k, 0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      evict_in_vld = 1'b0; evict_in_id = 4'd0; evict_in_addr = 40'd0; evict_in_data = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd0; bresp = 2'b00;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic push(input int id, input logic [39:0] addr, input int k);
      evict_in_vld = 1'b1; evict_in_id = 4'(id); evict_in_addr = addr; evict_in_data = line_of(k);
      tick();
      evict_in_vld = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (evict_in_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b expected 1", evict_in_rdy); end
      tests++; if ({awvalid, wvalid, bready, clean_en} !== 4'b0000) begin
         fails++; $display("FAIL reset_valids: got %b expected 0000", {awvalid, wvalid, bready, clean_en}); end
   endtask

   task automatic test_single_line();
      do_reset();
      awready = 1'b1; wready = 1'b1;
      push(3, 40'h1000, 1);
      tests++; if (awvalid !== 1'b1 || awaddr !== 40'h1000 || awid !== 4'd0) begin
         fails++; $display("FAIL single_aw: got v=%b addr=%h id=%h expected 1/1000/0", awvalid, awaddr, awid); end
      tests++; if (awlen !== 8'd3 || awsize !== 3'd4 || awburst !== 2'b01) begin
         fails++; $display("FAIL single_awfields: got len=%0d size=%0d burst=%0d expected 3/4/1", awlen, awsize, awburst); end
      tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL single_w_before_aw: got %b expected 0", wvalid); end
      tick();
      for (int b = 0; b < 4; b++) begin
         tests++; if (wvalid !== 1'b1 || wdata !== beat_of(1, b) || wlast !== (b == 3) || wstrb !== 16'hFFFF) begin
            fails++; $display("FAIL single_beat%0d: got v=%b d=%h last=%b strb=%h", b, wvalid, wdata, wlast, wstrb); end
         tick();
      end
      tests++; if (wvalid !== 1'b0 || bready !== 1'b1 || clean_en !== 1'b0) begin
         fails++; $display("FAIL single_after_w: got wv=%b br=%b ce=%b expected 0/1/0", wvalid, bready, clean_en); end
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      tests++; if (clean_en !== 1'b1 || clean_id !== 4'd3 || bready !== 1'b0) begin
         fails++; $display("FAIL single_clean: got en=%b id=%0d br=%b expected 1/3/0", clean_en, clean_id, bready); end
      tick();
      tests++; if (clean_en !== 1'b0) begin fails++; $display("FAIL single_clean_pulse: got %b expected 0", clean_en); end
   endtask

   task automatic test_full();
      int got [$];
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tests++; if (evict_in_rdy !== 1'b1) begin fails++; $display("FAIL full_rdy_push%0d: got %b expected 1", i, evict_in_rdy); end
         push(i, 40'h2000 + 40'(i * 64), 16 + i);
      end
      tests++; if (evict_in_rdy !== 1'b0) begin fails++; $display("FAIL full_rdy_low: got %b expected 0", evict_in_rdy); end
      evict_in_vld = 1'b1; evict_in_id = 4'd4; evict_in_addr = 40'h2100; evict_in_data = line_of(20);
      tick();
      tests++; if (evict_in_rdy !== 1'b0 || awvalid !== 1'b1 || awaddr !== 40'h2000) begin
         fails++; $display("FAIL full_hold: got rdy=%b awv=%b addr=%h expected 0/1/2000", evict_in_rdy, awvalid, awaddr); end
      awready = 1'b1; tick(); awready = 1'b0;
      wready = 1'b1; for (int b = 0; b < 4; b++) tick(); wready = 1'b0;
      bvalid = 1'b1;
      tests++; if (bready !== 1'b1 || evict_in_rdy !== 1'b0) begin
         fails++; $display("FAIL full_retire_cycle: got br=%b rdy=%b expected 1/0", bready, evict_in_rdy); end
      tick();
      bvalid = 1'b0;
      tests++; if (evict_in_rdy !== 1'b1 || clean_en !== 1'b1 || clean_id !== 4'd0) begin
         fails++; $display("FAIL full_rdy_next: got rdy=%b ce=%b id=%0d expected 1/1/0", evict_in_rdy, clean_en, clean_id); end
      tick();
      evict_in_vld = 1'b0;
      tests++; if (evict_in_rdy !== 1'b0) begin fails++; $display("FAIL full_refill: got %b expected 0", evict_in_rdy); end
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
      for (int c = 0; c < 60 && got.size() < 4; c++) begin
         tick();
         if (clean_en === 1'b1) got.push_back(int'(clean_id));
      end
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      tests++; if (got.size() != 4) begin fails++; $display("FAIL full_drain_count: got %0d expected 4", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         tests++; if (got[i] != i + 1) begin fails++; $display("FAIL full_drain_order%0d: got %0d expected %0d", i, got[i], i + 1); end
      end
   endtask

   task automatic test_wready_stall();
      int         idx [6] = '{0, 1, 1, 1, 2, 3};
      logic [5:0] rdy_pat = 6'b111001;
      do_reset();
      awready = 1'b1;
      push(5, 40'h3000, 5);
      tick();
      for (int c = 0; c < 6; c++) begin
         wready = rdy_pat[c];
         tests++; if (wvalid !== 1'b1 || wdata !== beat_of(5, idx[c]) || wlast !== (idx[c] == 3)) begin
            fails++; $display("FAIL stall_cyc%0d: got v=%b d=%h last=%b expected beat %0d", c, wvalid, wdata, wlast, idx[c]); end
         tick();
      end
      wready = 1'b0;
      tests++; if (wvalid !== 1'b0 || bready !== 1'b1) begin
         fails++; $display("FAIL stall_done: got wv=%b br=%b expected 0/1", wvalid, bready); end
      bvalid = 1'b1; tick(); bvalid = 1'b0;
      tests++; if (clean_en !== 1'b1 || clean_id !== 4'd5) begin
         fails++; $display("FAIL stall_clean: got en=%b id=%0d expected 1/5", clean_en, clean_id); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      awready = 1'b1; wready = 1'b1;
      push(6, 40'h4000, 6);
      push(7, 40'h4040, 7);
      for (int k = 0; k < 8; k++) begin
         tests++; if (wvalid !== 1'b1 || wdata !== beat_of(k < 4 ? 6 : 7, k % 4) || wlast !== (k % 4 == 3)) begin
            fails++; $display("FAIL b2b_beat%0d: got v=%b d=%h last=%b", k, wvalid, wdata, wlast); end
         tests++; if (bready !== (k >= 4)) begin fails++; $display("FAIL b2b_bready%0d: got %b expected %b", k, bready, k >= 4); end
         tick();
      end
      for (int n = 0; n < 2; n++) begin
         for (int d = 0; d < 10; d++) tick();
         tests++; if (bready !== 1'b1 || clean_en !== 1'b0) begin
            fails++; $display("FAIL b2b_wait%0d: got br=%b ce=%b expected 1/0", n, bready, clean_en); end
         bvalid = 1'b1; tick(); bvalid = 1'b0;
         tests++; if (clean_en !== 1'b1 || clean_id !== 4'(6 + n)) begin
            fails++; $display("FAIL b2b_clean%0d: got en=%b id=%0d expected 1/%0d", n, clean_en, clean_id, 6 + n); end
      end
      tests++; if (bready !== 1'b0) begin fails++; $display("FAIL b2b_bready_end: got %b expected 0", bready); end
   endtask

   task automatic test_mid_burst_reset();
      do_reset();
      awready = 1'b1; wready = 1'b1;
      push(9, 40'h5000, 9);
      tick();
      tick();
      tick();
      tests++; if (wdata !== beat_of(9, 2)) begin fails++; $display("FAIL rst_at_beat2: got %h expected %h", wdata, beat_of(9, 2)); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests++; if ({awvalid, wvalid, bready, evict_in_rdy} !== 4'b0001) begin
         fails++; $display("FAIL rst_mid_state: got %b expected 0001", {awvalid, wvalid, bready, evict_in_rdy}); end
      push(10, 40'h6000, 10);
      tests++; if (awvalid !== 1'b1 || awaddr !== 40'h6000) begin
         fails++; $display("FAIL rst_new_aw: got v=%b addr=%h expected 1/6000", awvalid, awaddr); end
      tick();
      tests++; if (wvalid !== 1'b1 || wdata !== beat_of(10, 0) || wlast !== 1'b0) begin
         fails++; $display("FAIL rst_new_beat0: got v=%b d=%h last=%b", wvalid, wdata, wlast); end
      for (int b = 0; b < 4; b++) tick();
      bvalid = 1'b1; tick(); bvalid = 1'b0;
      tests++; if (clean_en !== 1'b1 || clean_id !== 4'd10) begin
         fails++; $display("FAIL rst_new_clean: got en=%b id=%0d expected 1/10", clean_en, clean_id); end
   endtask

`ifdef L1D_EVICT_BERR_EN
   task automatic test_berr();
      do_reset();
      awready = 1'b1; wready = 1'b1;
      push(1, 40'h7000, 11);
      push(2, 40'h7040, 12);
      for (int c = 0; c < 8; c++) tick();
      bvalid = 1'b1; bresp = 2'b00; tick();
      tests++; if (clean_en !== 1'b1 || berr_en !== 1'b0 || berr_sticky !== 1'b0) begin
         fails++; $display("FAIL berr_ok: got ce=%b be=%b st=%b expected 1/0/0", clean_en, berr_en, berr_sticky); end
      bresp = 2'b10; tick();
      bvalid = 1'b0; bresp = 2'b00;
      tests++; if (clean_en !== 1'b1 || clean_id !== 4'd2 || berr_en !== 1'b1 || berr_sticky !== 1'b1) begin
         fails++; $display("FAIL berr_err: got ce=%b id=%0d be=%b st=%b expected 1/2/1/1", clean_en, clean_id, berr_en, berr_sticky); end
      tick();
      tests++; if (berr_en !== 1'b0 || berr_sticky !== 1'b1) begin
         fails++; $display("FAIL berr_hold: got be=%b st=%b expected 0/1", berr_en, berr_sticky); end
      do_reset();
      tests++; if (berr_sticky !== 1'b0) begin fails++; $display("FAIL berr_reset: got %b expected 0", berr_sticky); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_line();
      test_full();
      test_wready_stall();
      test_back_to_back();
      test_mid_burst_reset();
`ifdef L1D_EVICT_BERR_EN
      test_berr();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/l1d_evict_wr_adapter.md
Name: l1d_evict_wr_adapter

Overview:
- Parametrised eviction write adapter for the L1D data path; the next generation of the single-line write adapter in the data pipe.
- Accepts whole dirty cache lines read out of the data RAM and holds them in a DEPTH-entry eviction buffer.
- Converts each line into one AXI INCR write burst (AW + BEATS W beats) and retires entries in order on B response.
- Pulses evict_dat_ram_clean back to the tag/evict logic when a line is durably written.

Parameters:
- LINE_W, 512, cache line width in bits
- DATA_W, 128, AXI W data width; LINE_W % DATA_W == 0, DATA_W power of two ≥ 8
- ADDR_W, 40, line address width (byte address, line aligned)
- ID_W, 4, eviction id width (evict buffer/RAM slot id from the data pipe)
- AXI_ID_W, 4, AXI id width
- AXI_ID, 0, constant awid used for all bursts (guarantees in-order B)
- DEPTH, 4, eviction buffer entries, power of two ≥ 2

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- evict_in_vld  in  1  eviction line valid
- evict_in_rdy  out  1  buffer can accept
- evict_in_id  in  ID_W  eviction id
- evict_in_addr  in  ADDR_W  line byte address
- evict_in_data  in  LINE_W  line data, beat 0 = bits [DATA_W-1:0]
- evict_dat_ram_clean_en  out  1  one-cycle pulse, line written
- evict_dat_ram_clean_id  out  ID_W  id of cleaned line
- axi_awvalid  out  1;  axi_awready  in  1;  axi_awid  out  AXI_ID_W;  axi_awaddr  out  ADDR_W
- axi_awburst  out  2;  axi_awsize  out  3;  axi_awlen  out  8
- axi_wvalid  out  1;  axi_wready  in  1;  axi_wdata  out  DATA_W;  axi_wstrb  out  DATA_W/8;  axi_wlast  out  1
- axi_bvalid  in  1;  axi_bready  out  1;  axi_bid  in  AXI_ID_W;  axi_bresp  in  2

Behaviour:
- Interface: one clock clk; rst_n is synchronous, active-low.
- Buffer pointers:
  - Four pointers, each log2(DEPTH)+1 bits, all wrap naturally: wr_ptr (push), aw_ptr (next AW), w_ptr (next W line), b_ptr (retire).
  - Entry stores id, addr, line data.
- Push:
  - Push on evict_in_vld && evict_in_rdy.
  - evict_in_rdy = (wr_ptr - b_ptr) != DEPTH, registered-state only. No same-cycle bypass: when full, a concurrent retire does not raise rdy until the next cycle.
- AW channel:
  - axi_awvalid = aw_ptr != wr_ptr; fields taken from entry[aw_ptr].
  - awburst = 2'b01; awsize = log2(DATA_W/8); awlen = LINE_W/DATA_W - 1; awid = AXI_ID.
  - aw_ptr advances on awvalid && awready. Fields are held stable while awvalid && !awready.
- W channel:
  - Sends beats only for lines whose AW has been accepted: wvalid = w_ptr != aw_ptr.
  - Beat counter beat_cnt, log2(BEATS) bits (1 bit min). wdata = entry[w_ptr] slice beat_cnt; wstrb all ones.
  - wlast = beat_cnt == BEATS-1.
  - On a W handshake, beat_cnt increments. On the wlast handshake, beat_cnt resets to 0 and w_ptr advances.
  - Data, strobe and last are stable under backpressure.
- B channel:
  - axi_bready = b_ptr != w_ptr, i.e. only while a fully sent line is outstanding.
  - On bvalid && bready: b_ptr advances; evict_dat_ram_clean_en = 1 and clean_id = entry[b_ptr].id, registered (one cycle after the B handshake).
  - bid is not checked (single AXI_ID); bresp is ignored unless the optional feature is enabled.
- Simultaneous events: push, AW, W, B may all fire in one cycle; each pointer is updated independently. An AW handshake and the first W beat of the same line cannot fire in the same cycle (W waits for the AW pointer update).
- Reset (including mid-burst): all pointers, beat_cnt, clean_en = 0; evict_in_rdy = 1 after reset; awvalid/wvalid/bready/clean_en = 0. In-flight bursts are abandoned; the system resets the interconnect together.
- Latency:
  - Push to awvalid: 1 cycle.
  - AW accept to first wvalid: 1 cycle.
  - Idle-bus line drain: BEATS cycles.

Optional Feature:
- Macro L1D_EVICT_BERR_EN.
- Defined:
  - Adds outputs evict_berr_en (1, pulse aligned with clean_en) and evict_berr_sticky (1, set on any bresp != 2'b00, cleared only by reset).
  - clean_en still pulses (line is not retried).
- Undefined: ports absent, bresp ignored.

Test Plan:
- Single line, LINE_W=512, DATA_W=128, addr 0x1000, id 3, all ready=1 -> AW awlen=3, awsize=4, awburst=1; 4 W beats, wlast on the 4th; clean_en pulse with id 3 one cycle after the B handshake.
- Fill 4 lines with awready=0 -> evict_in_rdy=0 after the 4th push; 5th vld held; one B retire -> rdy=1 the following cycle, not the same cycle.
- wready toggled 1,0,0,1 mid-burst -> wdata/wlast held stable while stalled; beat order 0..3 preserved.
- Two back-to-back lines, bvalid delayed 10 cycles each -> bready low until the line's wlast is accepted; clean ids in push order.
- rst_n low during beat 2 of a burst -> next cycle awvalid=wvalid=bready=0, rdy=1; a new push restarts at beat 0.
- With L1D_EVICT_BERR_EN, bresp=2'b10 on the 2nd line -> berr_en pulses with that clean, sticky=1 until reset.
